// File: rtl/dual_port_bram_be.sv
// True dual-port RAM with per-lane byte enables, 1/2-cycle read latency, per-port
// read-during-write mode, same-address write collision flag and optional post-reset zero sweep.
module dual_port_bram_be #(
   parameter int DATA           = 72,
   parameter int LANE           = 9,
   parameter int ADDR           = 10,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE_A     = 0,
   parameter int RDW_MODE_B     = 0,
   parameter int CLEAR_ON_RESET = 0,
   localparam int LANES         = DATA / LANE
) (
   input  logic             clk,
   input  logic             rst,
   output logic             init_busy,
   output logic             collision,
   input  logic             a_en,
   input  logic             a_wr,
   input  logic [LANES-1:0] a_be,
   input  logic [ADDR-1:0]  a_addr,
   input  logic [DATA-1:0]  a_din,
   output logic [DATA-1:0]  a_dout,
   output logic             a_valid,
   input  logic             b_en,
   input  logic             b_wr,
   input  logic [LANES-1:0] b_be,
   input  logic [ADDR-1:0]  b_addr,
   input  logic [DATA-1:0]  b_din,
   output logic [DATA-1:0]  b_dout,
   output logic             b_valid
);

   localparam int DEPTH = 1 << ADDR;

   if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
      $error("dual_port_bram_be: READ_LATENCY must be 1 or 2");
   end
   if (DATA % LANE != 0) begin : g_bad_lane
      $error("dual_port_bram_be: DATA must be a multiple of LANE");
   end

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t            state, state_nxt;
   logic [ADDR-1:0]   cnt, cnt_nxt;
   logic              clr_we;
   logic [DATA-1:0]   mem [0:DEPTH-1];

   logic a_acc, a_we, a_re, b_acc, b_we, b_re;
   logic [DATA-1:0] a_d1, b_d1;
   logic            a_v1, b_v1;

   function automatic logic [DATA-1:0] merge_lanes(input logic [DATA-1:0] old_word,
                                                   input logic [DATA-1:0] new_word,
                                                   input logic [LANES-1:0] be);
      logic [DATA-1:0] res;
      res = old_word;
      for (int i = 0; i < LANES; i++)
         if (be[i]) res[i*LANE +: LANE] = new_word[i*LANE +: LANE];
      return res;
   endfunction

   // Clear sweep: one zero write per cycle, then hand over to the ports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_we    = 1'b0;
      case (state)
         S_CLEAR: begin
            clr_we  = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == '1) state_nxt = S_READY;
         end
         default: ;
      endcase
   end

   assign init_busy = (state == S_CLEAR);

   assign a_acc = a_en & ~init_busy;
   assign a_we  = a_acc & a_wr;
   assign a_re  = a_acc & ~a_wr;
   assign b_acc = b_en & ~init_busy;
   assign b_we  = b_acc & b_wr;
   assign b_re  = b_acc & ~b_wr;

   // Port A is applied last so it owns lanes both ports enable on the same word.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt] <= '0;
      end else begin
         for (int i = 0; i < LANES; i++)
            if (b_we && b_be[i]) mem[b_addr][i*LANE +: LANE] <= b_din[i*LANE +: LANE];
         for (int i = 0; i < LANES; i++)
            if (a_we && a_be[i]) mem[a_addr][i*LANE +: LANE] <= a_din[i*LANE +: LANE];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_d1 <= '0;
         a_v1 <= 1'b0;
      end else begin
         a_v1 <= a_re;
         if (a_re) begin
            a_d1 <= mem[a_addr];
         end else if (a_we) begin
            if (RDW_MODE_A == 1)      a_d1 <= mem[a_addr];
            else if (RDW_MODE_A == 2) a_d1 <= merge_lanes(mem[a_addr], a_din, a_be);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_d1 <= '0;
         b_v1 <= 1'b0;
      end else begin
         b_v1 <= b_re;
         if (b_re) begin
            b_d1 <= mem[b_addr];
         end else if (b_we) begin
            if (RDW_MODE_B == 1)      b_d1 <= mem[b_addr];
            else if (RDW_MODE_B == 2) b_d1 <= merge_lanes(mem[b_addr], b_din, b_be);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) collision <= 1'b0;
      else     collision <= a_we & b_we & (a_addr == b_addr) & (|(a_be & b_be));
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA-1:0] a_d2, b_d2;
      logic            a_v2, b_v2;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            a_d2 <= '0;
            a_v2 <= 1'b0;
            b_d2 <= '0;
            b_v2 <= 1'b0;
         end else begin
            a_d2 <= a_d1;
            a_v2 <= a_v1;
            b_d2 <= b_d1;
            b_v2 <= b_v1;
         end
      end
      assign a_dout  = a_d2;
      assign a_valid = a_v2;
      assign b_dout  = b_d2;
      assign b_valid = b_v2;
   end else begin : g_lat1
      assign a_dout  = a_d1;
      assign a_valid = a_v1;
      assign b_dout  = b_d1;
      assign b_valid = b_v1;
   end

endmodule

// File: doc/dual_port_bram_be.md
# dual_port_bram_be

True dual-port block RAM with per-lane byte enables, configurable read latency (1 or 2), per-port read-during-write mode, same-address write collision detection, and an optional post-reset clear sweep. It is the parametrised successor of the team's basic dual-port BRAM. It serves as the shared storage primitive behind task queues and argument buffers where two independent agents read and write a common memory.

## Interface
- `DATA`, 72: word width in bits; must be a multiple of `LANE`.
- `LANE`, 9: bits per byte-enable lane; `LANES = DATA/LANE`.
- `ADDR`, 10: address width; depth = 2^ADDR words.
- `READ_LATENCY`, 1: 1 or 2 cycles; other values are a synthesis-time error.
- `RDW_MODE_A`, 0: port A read-during-write mode: 0 NO_CHANGE, 1 READ_FIRST, 2 WRITE_FIRST.
- `RDW_MODE_B`, 0: same encoding, for port B.
- `CLEAR_ON_RESET`, 0: when 1, zero every word after reset.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `init_busy`  out  1  high while the clear sweep runs; requests are ignored while high.
- `collision`  out  1  one-cycle pulse flagging a same-address write/write overlap.
- `a_en`, `b_en`  in  1  port request enable.
- `a_wr`, `b_wr`  in  1  1 = write, 0 = read; ignored when the enable is low.
- `a_be`, `b_be`  in  LANES  per-lane write enable.
- `a_addr`, `b_addr`  in  ADDR  word address.
- `a_din`, `b_din`  in  DATA  write data.
- `a_dout`, `b_dout`  out  DATA  read data.
- `a_valid`, `b_valid`  out  1  high for one cycle when `*_dout` carries a read result.

## Operation
- Reset, asynchronous, while `rst`=1: `*_dout`=0, `*_valid`=0, `collision`=0, pipeline registers=0, sweep counter=0, `init_busy`=CLEAR_ON_RESET. Memory contents are not reset.
- Clear FSM, active only when CLEAR_ON_RESET=1:
  - CLEAR: writes 0 to address `cnt` each cycle, `cnt` running 0 to 2^ADDR-1.
  - After the last address the FSM moves to READY and `init_busy` drops.
  - Port requests during CLEAR are dropped: no write, no valid.
  - `rst` asserted mid-sweep restarts the sweep from address 0.
- With CLEAR_ON_RESET=0 the block enters READY directly.
- Write (en=1, wr=1): lane i of `mem[addr]` is updated only where `be[i]`=1. `be`=0 is a legal no-op write.
- Write `*_dout` behaviour by mode:
  - NO_CHANGE: `*_dout` holds.
  - READ_FIRST: `*_dout` shows the pre-write word.
  - WRITE_FIRST: `*_dout` shows the merged post-write word.
- `*_valid` stays 0 on writes in every mode.
- Read (en=1, wr=0): returns `mem[addr]` and pulses `*_valid`.
- en=0: no memory access, `*_dout` holds, `*_valid`=0.
- Both ports write the same address in the same cycle:
  - Lanes enabled on both ports take port A data.
  - Lanes enabled on only one port take that port's data.
  - `collision` pulses on the next cycle if at least one lane overlaps.
- One port writes and the other reads the same address: the reader gets the old word, and `collision` is not asserted.

## Timing
- Requests are sampled at rising edge k.
- READ_LATENCY=1: `*_dout`/`*_valid` update at edge k.
- READ_LATENCY=2: an extra output register, so the update is at edge k+1. Back-to-back reads give one result per cycle with no bubbles.
- `collision` is registered: it is high for the cycle after the colliding edge.
- Clear sweep: first zero write at the first edge after `rst` falls, last write 2^ADDR-1 edges later. `init_busy` is low starting from the edge after the last write, and the first accepted request is sampled on that edge.
- Port addresses are independent; no ordering between ports beyond the collision rules.

## Test plan
- Write 0x0123456789ABCDEF01 to addr 5 on A with `a_be`=0xFF, then read addr 5 on B. Expect `b_valid`=1 with the same word at edge k (L=1) or k+1 (L=2).
- Write addr 7 with `a_be`=0x01 and `din` all-ones over a stored 0. Read back: only bits [8:0] are set.
- Read addr 3 (holding X), then write Y to addr 3 on port A, for each mode. Expect `a_dout`: X held (mode 0), X (mode 1), Y (mode 2). `a_valid`=0 on the write cycle.
- Both ports write addr 9: A=0x..AA with be=0x0F, B=0x..55 with be=0xFF. Expect lanes 0-3 from A, lanes 4-7 from B, and `collision`=1 for exactly one cycle.
- CLEAR_ON_RESET=1, ADDR=4: preload nonzero data, then pulse `rst`. Expect `init_busy`=1 for 16 cycles, then all 16 addresses read 0. Repeat with `rst` re-asserted at sweep count 8: the sweep restarts at 0 and again takes 16 cycles.
- Assert `rst` mid-stream of pipelined reads (L=2). Expect `*_dout`=0 and `*_valid`=0 immediately, with no stale valid after release.
